// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder: active-low segment
// patterns, special digit codes and the scan state enumeration.
package seven_seg_scan_decoder_pkg;

  // DIN[6:0] patterns (bit0..6 = segments a..g, a lit segment reads 0)
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_ERR   = 4'hF;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_FILTER = 2'd1,
    ST_HELD   = 2'd2
  } state_e;

  function automatic logic sel_is_multi(input logic [3:0] sel);
    return (sel & (sel - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder, shared with the
// display encoder side of the design.
module seg7_pattern_decode
  import seven_seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       err_o
);

  always_comb begin
    err_o = 1'b0;
    unique case (seg_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_BLANK: code_o = CODE_BLANK;
      default: begin
        code_o = CODE_ERR;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers a 4-digit BCD value from a scanned, active-low seven-segment bus:
// debounces each digit dwell, collects a frame of four captures, then publishes.
module seven_seg_scan_decoder
  import seven_seg_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  DIN,
  input  logic        D1,
  input  logic        D2,
  input  logic        D3,
  input  logic        D4,
  output logic [15:0] BCD,
  output logic [3:0]  DP,
  output logic        FRAME_VALID,
  output logic        SEG_ERR,
  output logic        SEL_ERR,
  output logic        STALLED
);

  localparam int             TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]     STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0]  TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [11:0]    IDLE_SAMPLE = 12'hFFF;

  // Sample layout: [11:8] = {D1,D2,D3,D4} (active-low), [7:0] = DIN
  logic [11:0]   in_q, last_q;
  state_e        state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [15:0]   slot_bcd_q, slot_bcd_d;
  logic [3:0]    slot_dp_q, slot_dp_d;
  logic [3:0]    mask_q, mask_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    dp_q, dp_d;
  logic          frame_valid_q, seg_err_q, sel_err_q, stalled_q;

  logic [3:0] sel, held_sel;
  logic       multi, changed, latch, frame_done;
  logic [3:0] dec_code;
  logic       dec_err;

  assign sel        = ~in_q[11:8];
  assign held_sel   = ~last_q[11:8];
  assign multi      = sel_is_multi(sel);
  assign changed    = in_q != last_q;
  assign frame_done = mask_q == 4'hF;

  // A digit is accepted once STABLE_CYCLES identical samples have been seen;
  // last_q still holds that stable sample even if the bus has just moved on.
  assign latch = (state_q == ST_FILTER) && (count_q == STABLE_MAX);

  seg7_pattern_decode u_decode (
    .seg_i  (last_q[6:0]),
    .code_o (dec_code),
    .err_o  (dec_err)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    if (sel == 4'd0 || multi) begin
      state_d = ST_BLANK;
      count_d = 8'd0;
    end else if (state_q == ST_BLANK || changed) begin
      state_d = ST_FILTER;
      count_d = 8'd1;
    end else if (latch) begin
      state_d = ST_HELD;
    end else if (count_q < STABLE_MAX) begin
      count_d = count_q + 8'd1;
    end
  end

  always_comb begin
    slot_bcd_d = slot_bcd_q;
    slot_dp_d  = slot_dp_q;
    if (latch) begin
      for (int i = 0; i < 4; i++) begin
        if (held_sel[i]) begin
          slot_bcd_d[4*i +: 4] = dec_code;
          slot_dp_d[i]         = ~last_q[7];
        end
      end
    end
    // A capture landing in the publish cycle belongs to the following frame
    mask_d = (frame_done ? 4'd0 : mask_q) | (latch ? held_sel : 4'd0);
    bcd_d  = frame_done ? slot_bcd_q : bcd_q;
    dp_d   = frame_done ? slot_dp_q  : dp_q;

    if (latch)                       timeout_d = '0;
    else if (timeout_q == TIMEOUT_MAX) timeout_d = timeout_q;
    else                             timeout_d = timeout_q + 1'b1;
  end

  // NOTE: all state uses non-blocking assignments and asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      in_q          <= IDLE_SAMPLE;
      last_q        <= IDLE_SAMPLE;
      state_q       <= ST_BLANK;
      count_q       <= 8'd0;
      slot_bcd_q    <= {4{CODE_BLANK}};
      slot_dp_q     <= 4'd0;
      mask_q        <= 4'd0;
      timeout_q     <= '0;
      bcd_q         <= {4{CODE_BLANK}};
      dp_q          <= 4'd0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      in_q          <= {D1, D2, D3, D4, DIN};
      last_q        <= in_q;
      state_q       <= state_d;
      count_q       <= count_d;
      slot_bcd_q    <= slot_bcd_d;
      slot_dp_q     <= slot_dp_d;
      mask_q        <= mask_d;
      timeout_q     <= timeout_d;
      bcd_q         <= bcd_d;
      dp_q          <= dp_d;
      frame_valid_q <= frame_done;
      seg_err_q     <= latch && dec_err;
      sel_err_q     <= multi;
      stalled_q     <= timeout_d == TIMEOUT_MAX;
    end
  end

  assign BCD         = bcd_q;
  assign DP          = dp_q;
  assign FRAME_VALID = frame_valid_q;
  assign SEG_ERR     = seg_err_q;
  assign SEL_ERR     = sel_err_q;
  assign STALLED     = stalled_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench: scans digit sequences onto the bus, queues the frames
// they should produce and compares every published frame against the queue.
module tb_seven_seg_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 200;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } frame_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  DIN;
  logic        D1, D2, D3, D4;
  logic [15:0] BCD;
  logic [3:0]  DP;
  logic        FRAME_VALID, SEG_ERR, SEL_ERR, STALLED;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;
  int     frames   = 0;
  int     frame_cyc = 0;
  int     seg_cnt  = 0;
  int     sel_cnt  = 0;
  frame_t exp_q[$];

  seven_seg_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DIN         (DIN),
    .D1          (D1),
    .D2          (D2),
    .D3          (D3),
    .D4          (D4),
    .BCD         (BCD),
    .DP          (DP),
    .FRAME_VALID (FRAME_VALID),
    .SEG_ERR     (SEG_ERR),
    .SEL_ERR     (SEL_ERR),
    .STALLED     (STALLED)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Independent digit -> bus byte table, dp off (bit7 high)
  function automatic logic [7:0] dig(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic drive(input logic [3:0] sel_n, input logic [7:0] din, input int cycles);
    {D1, D2, D3, D4} = sel_n;
    DIN = din;
    repeat (cycles) @(negedge CLK);
  endtask

  // pos 0 = D1 (most significant) .. 3 = D4
  task automatic dwell(input int pos, input logic [7:0] din, input int cycles);
    logic [3:0] onehot;
    onehot = 4'b1000 >> pos;
    drive(~onehot, din, cycles);
  endtask

  task automatic idle(input int cycles);
    drive(4'hF, 8'hFF, cycles);
  endtask

  task automatic expect_frame(input logic [15:0] bcd, input logic [3:0] dp);
    frame_t f;
    f.bcd = bcd;
    f.dp  = dp;
    exp_q.push_back(f);
  endtask

  always @(negedge CLK) begin : monitor
    frame_t f;
    if (RESET === 1'b1) begin
      if (SEG_ERR) seg_cnt++;
      if (SEL_ERR) sel_cnt++;
      if (FRAME_VALID) begin
        frames++;
        frame_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {16'd0, BCD}, 32'hFFFF_FFFF);
        end else begin
          f = exp_q.pop_front();
          check("frame_bcd", {16'd0, BCD}, {16'd0, f.bcd});
          check("frame_dp", {28'd0, DP}, {28'd0, f.dp});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int d4_cyc;
    int base;
    logic seen;

    RESET = 1'b0;
    {D1, D2, D3, D4} = 4'hF;
    DIN = 8'hFF;
    repeat (3) @(negedge CLK);
    check("rst_bcd", {16'd0, BCD}, 32'h0000_EEEE);
    check("rst_dp", {28'd0, DP}, 32'd0);
    check("rst_frame_valid", {31'd0, FRAME_VALID}, 32'd0);
    check("rst_seg_err", {31'd0, SEG_ERR}, 32'd0);
    check("rst_sel_err", {31'd0, SEL_ERR}, 32'd0);
    check("rst_stalled", {31'd0, STALLED}, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);

    // Basic scan 1,2,3,4 with 8-cycle dwells and latency of the fourth digit
    expect_frame(16'h1234, 4'b0000);
    dwell(0, dig(1), 8);
    dwell(1, dig(2), 8);
    dwell(2, dig(3), 8);
    d4_cyc = cyc;
    dwell(3, dig(4), 8);
    idle(10);
    check("scan_frames", frames, 1);
    check("latency", frame_cyc - (d4_cyc + 1), STABLE + 2);

    // A 3-cycle dwell on D2 is rejected; a 4-cycle dwell completes the frame
    dwell(0, dig(1), 8);
    dwell(1, dig(5), 3);
    dwell(2, dig(3), 8);
    dwell(3, dig(4), 8);
    idle(12);
    check("short_dwell_no_frame", frames, 1);
    expect_frame(16'h1234, 4'b0000);
    dwell(1, dig(2), STABLE);
    idle(10);
    check("min_dwell_frame", frames, 2);

    // Blank pattern with decimal point lit on D3
    expect_frame(16'h12E4, 4'b0010);
    dwell(0, dig(1), 8);
    dwell(1, dig(2), 8);
    dwell(2, 8'h7F, 8);
    dwell(3, dig(4), 8);
    idle(10);
    check("blank_dp_frames", frames, 3);

    // Undecodable pattern on D1
    base = seg_cnt;
    expect_frame(16'hF234, 4'b1000);
    dwell(0, 8'h55, 8);
    dwell(1, dig(2), 8);
    dwell(2, dig(3), 8);
    dwell(3, dig(4), 8);
    idle(10);
    check("seg_err_pulses", seg_cnt - base, 1);
    check("seg_err_frames", frames, 4);

    // D1 and D4 active together leave the slots alone
    base = sel_cnt;
    expect_frame(16'h9876, 4'b0000);
    dwell(0, dig(9), 8);
    drive(4'b0110, dig(0), 1);
    dwell(1, dig(8), 8);
    dwell(2, dig(7), 8);
    dwell(3, dig(6), 8);
    idle(10);
    check("sel_err_pulses", sel_cnt - base, 1);
    check("sel_err_frames", frames, 5);

    // Idle bus -> STALLED, cleared by the next capture
    idle(100);
    check("not_yet_stalled", {31'd0, STALLED}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      idle(1);
      seen = STALLED;
    end
    check("stalled_asserts", {31'd0, seen}, 32'd1);
    idle(5);
    check("stalled_holds", {31'd0, STALLED}, 32'd1);
    dwell(1, dig(3), 8);
    check("stalled_clears", {31'd0, STALLED}, 32'd0);

    // Reset after two captures discards the partial frame
    dwell(0, dig(1), 8);
    dwell(1, dig(2), 8);
    idle(1);
    #3 RESET = 1'b0;
    #1;
    check("async_rst_bcd", {16'd0, BCD}, 32'h0000_EEEE);
    check("async_rst_dp", {28'd0, DP}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    dwell(2, dig(7), 8);
    dwell(3, dig(8), 8);
    idle(10);
    check("partial_discarded", frames, 5);
    expect_frame(16'h5678, 4'b0000);
    dwell(0, dig(5), 8);
    dwell(1, dig(6), 8);
    idle(10);
    check("post_reset_frames", frames, 6);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 The block SHALL use one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Parameter STABLE_CYCLES, default 4: the number of consecutive identical samples required to accept a digit (legal range 2..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 65536: the number of cycles without a new digit capture before STALLED asserts.
REQ-004 CLK  input  1  rising-edge system clock.
REQ-005 RESET  input  1  asynchronous active-low reset.
REQ-006 DIN  input  8  multiplexed segment bus, active-low: bit0..6 = segments a..g, bit7 = dp.
REQ-007 D1, D2, D3, D4  input  1 each  digit selects, active-low; D1 is the most significant digit.
REQ-008 BCD  output  16  decoded digits, D1 in [15:12] through D4 in [3:0].
REQ-009 DP  output  4  decimal-point state per digit, active-high, D1 in bit3.
REQ-010 FRAME_VALID  output  1  one-cycle pulse when BCD/DP update.
REQ-011 SEG_ERR  output  1  one-cycle pulse when an accepted pattern is not in the decode table.
REQ-012 SEL_ERR  output  1  one-cycle pulse when a sample has more than one select active.
REQ-013 STALLED  output  1  level; high while no digit has been accepted for TIMEOUT_CYCLES.

Function
REQ-014 Inputs SHALL be registered once; the sample is {D1..D4, DIN} from that register.
REQ-015 State machine SHALL be: BLANK (no select active), FILTER (one select active, counting), HELD (digit accepted, waiting for the select to change).
REQ-016 Transitions SHALL be:
- BLANK->FILTER on one active select.
- FILTER->HELD when the stable count reaches STABLE_CYCLES.
- Any state->FILTER with count=1 on a changed one-hot sample.
- Any state->BLANK on all selects inactive.
REQ-017 The stable count SHALL saturate and SHALL restart on any change of select or DIN.
REQ-018 On FILTER->HELD the block SHALL latch the decoded digit and dp into that digit's shadow slot and set its captured bit; at most one latch per dwell.
REQ-019 Decode table (DIN[6:0] hex -> digit) SHALL be:
- 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
- 7F->blank, coded 4'hE.
- Any other value SHALL be coded 4'hF and pulse SEG_ERR in the latch cycle.
REQ-020 A sample with two or more selects active SHALL pulse SEL_ERR, return to BLANK, and leave the shadow slots unchanged.
REQ-021 When all four captured bits are set, the block SHALL, on the next cycle, copy the shadow slots to BCD/DP, pulse FRAME_VALID, and clear the captured mask.
REQ-022 Latency SHALL be STABLE_CYCLES+2 cycles from the first register-stage sample of the fourth digit to FRAME_VALID.
REQ-023 A re-captured digit before frame completion SHALL overwrite its slot (last value wins).
REQ-024 If frame completion and a new latch occur in the same cycle, the new latch SHALL go to the next frame's mask.
REQ-025 The timeout counter SHALL clear on every latch; STALLED SHALL assert when it reaches TIMEOUT_CYCLES, hold, and deassert on the next latch.

Reset
REQ-026 Reset SHALL force the following, all with immediate asynchronous effect:
- BCD = 16'hEEEE (all blank) and DP = 0.
- FRAME_VALID, SEG_ERR, SEL_ERR, STALLED = 0.
- State = BLANK; mask, counters, and input register cleared (selects inactive).
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first FRAME_VALID after release SHALL require four fresh captures.

Structure
REQ-028 The shared package SHALL hold the segment-pattern constants, the blank/error codes (4'hE/4'hF), and the state enumeration.
REQ-029 Pattern-to-digit decoding SHALL be a separate combinational sub-module, seg7_pattern_decode, reusable by the display encoder.

Verification
REQ-030 Scan digits 1,2,3,4 with 8-cycle dwell each, STABLE_CYCLES=4 -> one FRAME_VALID pulse with BCD=16'h1234, DP=0.
REQ-031 Dwell of 3 cycles on D2 -> no latch for D2 and no FRAME_VALID until a dwell of at least 4 cycles.
REQ-032 D3 dwell with DIN=8'h7F-with-dp (DIN=8'h7F except bit7=0) -> BCD[7:4]=4'hE, DP[1]=1.
REQ-033 DIN=8'h55 on D1 held 8 cycles -> one SEG_ERR pulse; next frame BCD[15:12]=4'hF.
REQ-034 D1 and D4 low together -> SEL_ERR pulse and no slot change; an idle bus for TIMEOUT_CYCLES -> STALLED=1, cleared by the next capture.
REQ-035 Reset asserted after two captures, then a full scan of 5,6,7,8 -> exactly one FRAME_VALID with BCD=16'h5678.
